// File: rtl/serial_pkg.sv
// Shared definitions for the serial link blocks (PISO serialiser and SIPO deframer).
package serial_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;

  localparam int SER_WIDTH = 4;

  // Bit-count width able to hold the values 0..width.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_deframer_if.sv
// Serial-input and parallel-output signal bundle of the SIPO deframer.
interface sipo_deframer_if import serial_pkg::*; #(
  parameter int WIDTH = SER_WIDTH
);
  localparam int CW = count_width(WIDTH);

  logic             serial_in;
  logic             bit_valid;
  logic             frame_start;
  logic             out_ready;
  logic             overrun_clr;
  logic [WIDTH-1:0] parallel_out;
  logic             out_valid;
  logic             overrun;
  logic             framing_err;
  logic [CW-1:0]    bit_count;

  modport master (
    output serial_in, bit_valid, frame_start, out_ready, overrun_clr,
    input  parallel_out, out_valid, overrun, framing_err, bit_count
  );

  modport slave (
    input  serial_in, bit_valid, frame_start, out_ready, overrun_clr,
    output parallel_out, out_valid, overrun, framing_err, bit_count
  );

endinterface

// File: rtl/sipo_deframer_out_reg.sv
// One-entry valid/ready output register; a completed word that cannot be
// stored because the held word is still pending is dropped and flagged.
module sipo_out_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             out_ready,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] data_r;
  logic             valid_r;
  logic             overrun_r;
  logic             space_s;
  logic             drop_s;

  // A slot is free when empty or when the held word leaves on this edge.
  always_comb begin
    space_s = (!valid_r) || out_ready;
    drop_s  = load && !space_s;
  end

  // Output word, valid flag and sticky overrun (a new drop beats a clear).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r    <= {WIDTH{1'b0}};
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      if (load && space_s) begin
        data_r  <= word;
        valid_r <= 1'b1;
      end else if (valid_r && out_ready) begin
        valid_r <= 1'b0;
      end
      if (drop_s) begin
        overrun_r <= 1'b1;
      end else if (overrun_clr) begin
        overrun_r <= 1'b0;
      end
    end
  end

  assign parallel_out = data_r;
  assign out_valid    = valid_r;
  assign overrun      = overrun_r;

endmodule

// File: rtl/sipo_deframer.sv
// MSB-first serial-to-parallel deframer aligned by frame_start, with a
// registered valid/ready word output, overrun and framing-error reporting.
module sipo_deframer import serial_pkg::*; #(
  parameter int WIDTH      = SER_WIDTH,
  parameter bit CONTINUOUS = 1'b0
) (
  input logic            clk,
  input logic            reset,
  sipo_deframer_if.slave bus
);

  localparam int            CW       = count_width(WIDTH);
  localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_CNT  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [0:0]       state_r;
  logic [0:0]       state_s;
  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] shreg_s;
  logic [WIDTH-1:0] shifted_s;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_s;
  logic             framing_s;
  logic             framing_r;
  logic             complete_s;

  // Next-state logic: framing, shifting and word completion.
  always_comb begin
    shifted_s  = {shreg_r[WIDTH-2:0], bus.serial_in};
    state_s    = state_r;
    shreg_s    = shreg_r;
    count_s    = count_r;
    framing_s  = 1'b0;
    complete_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.bit_valid && bus.frame_start) begin
          shreg_s = shifted_s;
          count_s = ONE_CNT;
          state_s = ST_RECV;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (bus.bit_valid) begin
          shreg_s = shifted_s;
          if (bus.frame_start) begin
            // A marker at count 0 is a legal start in continuous mode.
            framing_s = (count_r != ZERO_CNT);
            count_s   = ONE_CNT;
          end else if (count_r == LAST_CNT) begin
            complete_s = 1'b1;
            count_s    = ZERO_CNT;
            state_s    = CONTINUOUS ? ST_RECV : ST_IDLE;
          end else begin
            count_s = count_r + ONE_CNT;
          end
        end else begin
          state_s = ST_RECV;
        end
      end
      default: begin
        state_s = ST_IDLE;
        count_s = ZERO_CNT;
      end
    endcase
  end

  // FSM, shift register, bit counter and framing-error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      shreg_r   <= {WIDTH{1'b0}};
      count_r   <= ZERO_CNT;
      framing_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      shreg_r   <= shreg_s;
      count_r   <= count_s;
      framing_r <= framing_s;
    end
  end

  sipo_out_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clk         (clk),
    .reset       (reset),
    .load        (complete_s),
    .word        (shifted_s),
    .out_ready   (bus.out_ready),
    .overrun_clr (bus.overrun_clr),
    .parallel_out(bus.parallel_out),
    .out_valid   (bus.out_valid),
    .overrun     (bus.overrun)
  );

  assign bus.framing_err = framing_r;
  assign bus.bit_count   = count_r;

endmodule

// File: tb/tb_sipo_deframer.sv
// Directed self-checking bench for sipo_deframer (WIDTH=4, both framing modes).
module tb_sipo_deframer;

  logic clk;
  logic reset;
  logic serial_in;
  logic bit_valid;
  logic frame_start;
  logic out_ready;
  logic overrun_clr;
  logic [3:0] piso_r;
  int checks;
  int errors;

  sipo_deframer_if #(.WIDTH(4)) if0 ();
  sipo_deframer_if #(.WIDTH(4)) if1 ();

  assign if0.serial_in   = serial_in;
  assign if0.bit_valid   = bit_valid;
  assign if0.frame_start = frame_start;
  assign if0.out_ready   = out_ready;
  assign if0.overrun_clr = overrun_clr;
  assign if1.serial_in   = serial_in;
  assign if1.bit_valid   = bit_valid;
  assign if1.frame_start = frame_start;
  assign if1.out_ready   = out_ready;
  assign if1.overrun_clr = overrun_clr;

  sipo_deframer #(.WIDTH(4), .CONTINUOUS(1'b0)) dut0 (
    .clk  (clk),
    .reset(reset),
    .bus  (if0.slave)
  );

  sipo_deframer #(.WIDTH(4), .CONTINUOUS(1'b1)) dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic b, input logic fs);
    bit_valid   = v;
    serial_in   = b;
    frame_start = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_po"},  32'(if0.parallel_out), 32'h0);
    check({tag, "_ov"},  32'(if0.out_valid),    32'h0);
    check({tag, "_orn"}, 32'(if0.overrun),      32'h0);
    check({tag, "_fe"},  32'(if0.framing_err),  32'h0);
    check({tag, "_bc"},  32'(if0.bit_count),    32'h0);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    serial_in   = 1'b0;
    bit_valid   = 1'b0;
    frame_start = 1'b0;
    out_ready   = 1'b0;
    overrun_clr = 1'b0;
    piso_r      = 4'h0;
    #12;
    check_all_zero("reset");
    check("reset_ov1", 32'(if1.out_valid), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Basic word 1011
    out_ready = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    check("basic_bc1", 32'(if0.bit_count), 32'h1);
    check("basic_ov_early", 32'(if0.out_valid), 32'h0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("basic_bc3", 32'(if0.bit_count), 32'h3);
    step(1'b1, 1'b1, 1'b0);
    check("basic_ov", 32'(if0.out_valid), 32'h1);
    check("basic_po", 32'(if0.parallel_out), 32'hB);
    check("basic_bc0", 32'(if0.bit_count), 32'h0);
    check("basic_fe", 32'(if0.framing_err), 32'h0);
    step(1'b0, 1'b0, 1'b0);
    check("basic_ov_drop", 32'(if0.out_valid), 32'h0);

    // PISO loopback of 4'h6
    piso_r = 4'h6;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, piso_r[3], (i == 0) ? 1'b1 : 1'b0);
      piso_r = {piso_r[2:0], 1'b0};
    end
    check("loop_ov", 32'(if0.out_valid), 32'h1);
    check("loop_po", 32'(if0.parallel_out), 32'h6);
    step(1'b0, 1'b0, 1'b0);

    // Resync: partial 11, then fresh word 0010
    step(1'b1, 1'b1, 1'b1);
    check("resync_fe0", 32'(if0.framing_err), 32'h0);
    step(1'b1, 1'b1, 1'b0);
    check("resync_bc2", 32'(if0.bit_count), 32'h2);
    step(1'b1, 1'b0, 1'b1);
    check("resync_fe1", 32'(if0.framing_err), 32'h1);
    check("resync_bc1", 32'(if0.bit_count), 32'h1);
    step(1'b1, 1'b0, 1'b0);
    check("resync_fe_once", 32'(if0.framing_err), 32'h0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("resync_ov", 32'(if0.out_valid), 32'h1);
    check("resync_po", 32'(if0.parallel_out), 32'h2);
    check("resync_fe_end", 32'(if0.framing_err), 32'h0);
    step(1'b0, 1'b0, 1'b0);

    // Backpressure: A then 5 with out_ready low
    out_ready = 1'b0;
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("bp_po_a", 32'(if0.parallel_out), 32'hA);
    check("bp_orn0", 32'(if0.overrun), 32'h0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    check("bp_hold", 32'(if0.parallel_out), 32'hA);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("bp_po_keep", 32'(if0.parallel_out), 32'hA);
    check("bp_ov_keep", 32'(if0.out_valid), 32'h1);
    check("bp_orn1", 32'(if0.overrun), 32'h1);
    out_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    check("bp_ov_taken", 32'(if0.out_valid), 32'h0);
    check("bp_orn_sticky", 32'(if0.overrun), 32'h1);
    overrun_clr = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    overrun_clr = 1'b0;
    check("bp_ov_clr", 32'(if0.out_valid), 32'h0);
    check("bp_orn_clr", 32'(if0.overrun), 32'h0);

    // Set beats clear: word 3 fills, word C overruns with overrun_clr high
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    overrun_clr = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    overrun_clr = 1'b0;
    check("setwins_orn", 32'(if0.overrun), 32'h1);
    check("setwins_po", 32'(if0.parallel_out), 32'h3);

    // Async reset mid-word with a pending word
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    check("ar_bc2", 32'(if0.bit_count), 32'h2);
    check("ar_ov_pre", 32'(if0.out_valid), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("areset");
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    check("ign_bc_a", 32'(if0.bit_count), 32'h0);
    step(1'b1, 1'b0, 1'b0);
    check("ign_bc_b", 32'(if0.bit_count), 32'h0);
    step(1'b1, 1'b1, 1'b0);
    check("ign_bc_c", 32'(if0.bit_count), 32'h0);
    check("ign_ov", 32'(if0.out_valid), 32'h0);

    // Continuous mode on dut1: C then 3, second completes as first is accepted
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b0;
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("cont_ov1", 32'(if1.out_valid), 32'h1);
    check("cont_po1", 32'(if1.parallel_out), 32'hC);
    step(1'b1, 1'b0, 1'b0);
    check("cont_bc1", 32'(if1.bit_count), 32'h1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    out_ready = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    check("cont_ov2", 32'(if1.out_valid), 32'h1);
    check("cont_po2", 32'(if1.parallel_out), 32'h3);
    check("cont_orn", 32'(if1.overrun), 32'h0);
    check("cont_fe", 32'(if1.framing_err), 32'h0);
    step(1'b0, 1'b0, 1'b0);
    check("cont_ov_end", 32'(if1.out_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
